reset_sequencer: RTL and testbench

- Parametrised power-on and reset sequencer that sits between the board reset button, the clocking wizard and the downstream clock domains (display, frame buffer, ray-tracing units).
- Pulses the PLL reset for a programmable width, then waits for lock. With timeout compiled in, it retries the PLL reset on a lock timeout.
- Releases per-domain resets one at a time with a programmable stagger; each release is synchronised to its own domain clock.
- Monitors lock loss and accepts a soft-reset request.

---
 rtl/reset_seq_pkg.sv | 21 ++
 rtl/reset_sync.sv | 22 ++
 rtl/reset_sequencer.sv | 173 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// retry counter width and a constant helper for sizing the cycle counter.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUNNING   = 2'd3
  } seq_state_t;

  localparam int RETRY_W = 4;

  // Largest of three cycle counts; sizes the shared cnt register.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously on arst, deasserts
// on the second rising edge of clk after arst goes low.
module reset_sync (
  input  logic clk,
  input  logic arst,
  output logic rst_out
);

  logic [1:0] sync_reg;

  // Shift zeros in after release; any arst assertion refills with ones at once.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], 1'b0};
    end
  end

  assign rst_out = sync_reg[1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / reset sequencer: pulses the PLL reset, waits for lock, then
// releases each downstream domain reset in turn with a fixed stagger.
// Lock loss restarts from the PLL reset; soft_rst_req re-releases domains only.
// Optional build macro RESET_SEQ_TIMEOUT_EN: retry the PLL reset when lock
// does not arrive within LOCK_TIMEOUT cycles, counting retries.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS    = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8,
  parameter int LOCK_TIMEOUT   = 65535
) (
  input  logic                   SYSCLK,
  input  logic                   RESET_BTN,
  input  logic                   locked,
  input  logic                   soft_rst_req,
  input  logic [NUM_DOMAINS-1:0] domain_clk,
  output logic                   pll_reset,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic [RETRY_W-1:0]     retry_count
);

  localparam int CNT_MAX = max3(HOLD_CYCLES, STAGGER_CYCLES, LOCK_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
`endif

  logic                   locked_meta_reg;
  logic                   locked_s_reg;
  seq_state_t             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [NUM_DOMAINS-1:0] rst_req_reg, rst_req_next;
  logic [NUM_DOMAINS-1:0] dom_arst;
`ifdef RESET_SEQ_TIMEOUT_EN
  logic [RETRY_W-1:0]     retry_reg, retry_next;
`endif

  // Bring the PLL lock flag into the SYSCLK domain.
  always_ff @(posedge SYSCLK or posedge RESET_BTN) begin
    if (RESET_BTN) begin
      locked_meta_reg <= 1'b0;
      locked_s_reg    <= 1'b0;
    end else begin
      locked_meta_reg <= locked;
      locked_s_reg    <= locked_meta_reg;
    end
  end

  // Sequencer state register; RESET_BTN restores the power-on picture at once.
  always_ff @(posedge SYSCLK or posedge RESET_BTN) begin
    if (RESET_BTN) begin
      state_reg   <= PLL_RST;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      rst_req_reg <= '1;
`ifdef RESET_SEQ_TIMEOUT_EN
      retry_reg   <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      rst_req_reg <= rst_req_next;
`ifdef RESET_SEQ_TIMEOUT_EN
      retry_reg   <= retry_next;
`endif
    end
  end

  // Next-state logic; lock loss takes priority over stagger ticks and soft resets.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + CNT_W'(1);
    idx_next     = idx_reg;
    rst_req_next = rst_req_reg;
`ifdef RESET_SEQ_TIMEOUT_EN
    retry_next   = retry_reg;
`endif
    case (state_reg)
      PLL_RST: begin
        if (cnt_reg == HOLD_LAST) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end
      end
      WAIT_LOCK: begin
        if (locked_s_reg) begin
          state_next = RELEASE;
          cnt_next   = '0;
          idx_next   = '0;
        end
`ifdef RESET_SEQ_TIMEOUT_EN
        else if (cnt_reg == LOCK_LAST) begin
          state_next = PLL_RST;
          cnt_next   = '0;
          if (retry_reg != '1) begin
            retry_next = retry_reg + RETRY_W'(1);
          end
        end
`endif
      end
      RELEASE: begin
        if (!locked_s_reg) begin
          state_next   = PLL_RST;
          cnt_next     = '0;
          rst_req_next = '1;
        end else if (cnt_reg == STAGGER_LAST) begin
          for (int d = 0; d < NUM_DOMAINS; d++) begin
            if (IDX_W'(d) == idx_reg) begin
              rst_req_next[d] = 1'b0;
            end
          end
          idx_next = idx_reg + IDX_W'(1);
          cnt_next = '0;
          if (idx_reg == IDX_LAST) begin
            state_next = RUNNING;
          end
        end
      end
      RUNNING: begin
        cnt_next = cnt_reg;
        if (!locked_s_reg) begin
          state_next   = PLL_RST;
          cnt_next     = '0;
          rst_req_next = '1;
        end else if (soft_rst_req) begin
          state_next   = RELEASE;
          cnt_next     = '0;
          idx_next     = '0;
          rst_req_next = '1;
        end
      end
      default: begin
        state_next = PLL_RST;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs decoded purely from the state register.
  always_comb begin
    pll_reset = (state_reg == PLL_RST);
    ready     = (state_reg == RUNNING);
  end

`ifdef RESET_SEQ_TIMEOUT_EN
  assign retry_count = retry_reg;
`else
  assign retry_count = '0;
`endif

  // One synchroniser per domain so each release lands on its own clock.
  generate
    for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
      assign dom_arst[gi] = rst_req_reg[gi] | RESET_BTN;
      reset_sync u_sync (
        .clk     (domain_clk[gi]),
        .arst    (dom_arst[gi]),
        .rst_out (domain_rst[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer (NUM_DOMAINS=3, HOLD=4, STAGGER=8,
// LOCK_TIMEOUT=100). Expected changes of {pll_reset, ready, retry_count}
// are queued with the SYSCLK edge number at which they must appear; a
// monitor compares every observed change. Domain resets are checked
// against their own clock edges.
module tb_reset_sequencer;

  localparam int ND = 3;

  logic          SYSCLK = 1'b0;
  logic          RESET_BTN = 1'b1;
  logic          locked = 1'b1;
  logic          soft_rst_req = 1'b0;
  logic          dclk0 = 1'b0, dclk1 = 1'b0, dclk2 = 1'b0;
  logic [ND-1:0] domain_clk;
  logic          pll_reset, ready;
  logic [ND-1:0] domain_rst;
  logic [3:0]    retry_count;

  assign domain_clk = {dclk2, dclk1, dclk0};

  // Domain clock edges land on times ending in 5, never on a SYSCLK event.
  always #50 SYSCLK = ~SYSCLK;
  always #35 dclk0 = ~dclk0;
  always #45 dclk1 = ~dclk1;
  always #65 dclk2 = ~dclk2;

  reset_sequencer #(
    .NUM_DOMAINS(ND), .HOLD_CYCLES(4), .STAGGER_CYCLES(8), .LOCK_TIMEOUT(100)
  ) dut (
    .SYSCLK(SYSCLK), .RESET_BTN(RESET_BTN), .locked(locked),
    .soft_rst_req(soft_rst_req), .domain_clk(domain_clk),
    .pll_reset(pll_reset), .domain_rst(domain_rst), .ready(ready),
    .retry_count(retry_count)
  );

  typedef struct {
    int         edge_n;
    logic [5:0] vec;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  edge_cnt;

  // Edge k = k-th SYSCLK rising edge after RESET_BTN falls.
  always @(posedge SYSCLK or posedge RESET_BTN) begin
    if (RESET_BTN) edge_cnt <= 0;
    else           edge_cnt <= edge_cnt + 1;
  end

  task automatic push_ev(input int e, input logic p, input logic r, input int rc);
    ev_t ev;
    ev.edge_n = e;
    ev.vec    = {p, r, 4'(rc)};
    exp_q.push_back(ev);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, got, want, edge_cnt);
    end
  endtask

  task automatic wait_edge(input int n);
    int g = 0;
    while (edge_cnt != n && g < 20000) begin
      @(negedge SYSCLK);
      g++;
    end
    if (g >= 20000) begin
      checks++;
      errors++;
      $display("FAIL wait_edge: edge %0d never reached, stuck at %0d", n, edge_cnt);
    end
  endtask

  task automatic dom_edge(input int i);
    case (i)
      0:       @(posedge dclk0);
      1:       @(posedge dclk1);
      default: @(posedge dclk2);
    endcase
  endtask

  // Domain i must stay in reset one own-clock edge after rst_req clears, then fall.
  task automatic dom_chk(input int i, input int rel);
    wait_edge(rel - 1);
    @(posedge SYSCLK);
    dom_edge(i);
    #2;
    chk($sformatf("dom%0d_hold_e%0d", i, rel), 32'(domain_rst[i]), 32'd1);
    dom_edge(i);
    #2;
    chk($sformatf("dom%0d_release_e%0d", i, rel), 32'(domain_rst[i]), 32'd0);
  endtask

  // Pulse RESET_BTN between clock edges, verify the instant reset picture.
  task automatic do_reset(input logic lock_val);
    @(negedge SYSCLK);
    #20 RESET_BTN = 1'b1;
    locked = lock_val;
    #1;
    chk("async_pll_reset", 32'(pll_reset), 32'd1);
    chk("async_ready", 32'(ready), 32'd0);
    chk("async_domain_rst", 32'(domain_rst), 32'h7);
    chk("async_retry", 32'(retry_count), 32'd0);
    repeat (3) @(negedge SYSCLK);
    RESET_BTN = 1'b0;
  endtask

  // Monitor: every change of the SYSCLK-side outputs must match the queue head.
  initial begin
    logic [5:0] prev, cur;
    ev_t e;
    prev = 6'b100000;
    forever begin
      @(negedge SYSCLK);
      cur = {pll_reset, ready, retry_count};
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: edge %0d vec %b, expected no change", edge_cnt, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.edge_n != edge_cnt || e.vec !== cur) begin
            errors++;
            $display("FAIL sb_event: got edge %0d vec %b, expected edge %0d vec %b",
                     edge_cnt, cur, e.edge_n, e.vec);
          end else begin
            $display("event edge %0d pll_reset=%b ready=%b retry=%0d ok",
                     edge_cnt, cur[5], cur[4], cur[3:0]);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit at edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge SYSCLK);
    chk("reset_pll_reset", 32'(pll_reset), 32'd1);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_domain_rst", 32'(domain_rst), 32'h7);
    chk("reset_retry", 32'(retry_count), 32'd0);

    // Normal power-up with lock already present.
    push_ev(4, 0, 0, 0);
    push_ev(29, 0, 1, 0);
    @(negedge SYSCLK);
    RESET_BTN = 1'b0;
    fork
      begin
        wait_edge(12);
        chk("pre_release_dom", 32'(domain_rst), 32'h7);
      end
      dom_chk(0, 13);
      dom_chk(1, 21);
      dom_chk(2, 29);
    join
    wait_edge(40);
    chk("running_dom", 32'(domain_rst), 32'h0);

    // Lock loss in RUNNING, restored a few cycles later.
    locked = 1'b0;
    push_ev(43, 1, 0, 0);
    push_ev(47, 0, 0, 0);
    push_ev(72, 0, 1, 0);
    wait_edge(43);
    chk("lockloss_dom", 32'(domain_rst), 32'h7);
    wait_edge(44);
    locked = 1'b1;
    wait_edge(80);

    // Soft reset from RUNNING; a second pulse during RELEASE is ignored.
    push_ev(81, 0, 0, 0);
    push_ev(105, 0, 1, 0);
    soft_rst_req = 1'b1;
    @(negedge SYSCLK);
    soft_rst_req = 1'b0;
    chk("soft_pll_reset", 32'(pll_reset), 32'd0);
    chk("soft_dom", 32'(domain_rst), 32'h7);
    fork
      begin
        wait_edge(90);
        soft_rst_req = 1'b1;
        @(negedge SYSCLK);
        soft_rst_req = 1'b0;
      end
      dom_chk(0, 89);
      dom_chk(1, 97);
      dom_chk(2, 105);
    join
    wait_edge(110);

    // RESET_BTN in the middle of RELEASE, then a clean restart.
    push_ev(0, 1, 0, 0);
    push_ev(4, 0, 0, 0);
    do_reset(1'b1);
    wait_edge(16);
    chk("dom0_low_before_btn", 32'(domain_rst[0]), 32'd0);
    push_ev(0, 1, 0, 0);
    do_reset(1'b1);
    push_ev(4, 0, 0, 0);
    push_ev(29, 0, 1, 0);
    wait_edge(35);

`ifdef RESET_SEQ_TIMEOUT_EN
    // Lock never arrives: timeout retries, counter saturates at 15.
    push_ev(0, 1, 0, 0);
    push_ev(4, 0, 0, 0);
    for (int n = 1; n <= 20; n++) begin
      push_ev(104 * n, 1, 0, (n > 15) ? 15 : n);
      push_ev(104 * n + 4, 0, 0, (n > 15) ? 15 : n);
    end
    do_reset(1'b0);
    wait_edge(2090);
    chk("retry_saturated", 32'(retry_count), 32'd15);
    push_ev(0, 1, 0, 0);
    do_reset(1'b1);
    push_ev(4, 0, 0, 0);
    push_ev(29, 0, 1, 0);
    wait_edge(35);
`else
    // Lock never arrives: WAIT_LOCK holds indefinitely, then lock releases it.
    push_ev(0, 1, 0, 0);
    push_ev(4, 0, 0, 0);
    do_reset(1'b0);
    wait_edge(1004);
    chk("nolock_pll_reset", 32'(pll_reset), 32'd0);
    chk("nolock_ready", 32'(ready), 32'd0);
    chk("nolock_retry", 32'(retry_count), 32'd0);
    chk("nolock_dom", 32'(domain_rst), 32'h7);
    locked = 1'b1;
    push_ev(1031, 0, 1, 0);
    wait_edge(1040);
`endif

    repeat (5) @(negedge SYSCLK);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
